// File: rtl/rsa_modexp.sv
// Square-and-multiply modular exponentiation (result = base^exp mod modulus) on a bit-serial
// interleaved modular multiplier. Optional operand range check: RSA_MODEXP_RANGE_CHECK_EN.
module rsa_modexp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_SQR, S_MUL, S_FIN, S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] base_r, exp_r, n_r;
  logic [WIDTH-1:0] br, acc;
  logic [WIDTH-1:0] x_sh, y_r, p_r;
  logic [IW-1:0]    cnt, idx;

  logic             accept, last, skip, range_err;
  logic [WIDTH:0]   n_ext, dbl, red, add;
  logic [WIDTH-1:0] prod;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == IW'(WIDTH - 1));

`ifdef RSA_MODEXP_RANGE_CHECK_EN
  assign range_err = (base_r >= n_r) || (n_r < WIDTH'(2));
`else
  assign range_err = 1'b0;
`endif

  assign skip = (n_r < WIDTH'(2)) || range_err;

  // One multiplier step: p is kept below n, so 2p and t+y both fit in WIDTH+1 bits.
  always_comb begin
    n_ext = {1'b0, n_r};
    dbl   = {p_r, 1'b0};
    red   = (dbl >= n_ext) ? dbl - n_ext : dbl;
    add   = x_sh[WIDTH-1] ? red + {1'b0, y_r} : red;
    prod  = WIDTH'((add >= n_ext) ? add - n_ext : add);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = S_LOAD;
      end
      S_LOAD: state_next = skip ? S_FIN : S_PRE;
      S_PRE:  if (last) state_next = S_SQR;
      S_SQR: begin
        if (last) begin
          if (exp_r[idx])      state_next = S_MUL;
          else if (idx == '0)  state_next = S_FIN;
          else                 state_next = S_SQR;
        end
      end
      S_MUL:  if (last) state_next = (idx == '0) ? S_FIN : S_SQR;
      S_FIN:  state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Each multiply's final cycle also loads the operands of the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r <= '0;
      exp_r  <= '0;
      n_r    <= '0;
      br     <= '0;
      acc    <= '0;
      x_sh   <= '0;
      y_r    <= '0;
      p_r    <= '0;
      cnt    <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            base_r <= base;
            exp_r  <= exp;
            n_r    <= modulus;
          end
        end
        S_LOAD: begin
          x_sh <= base_r;
          y_r  <= WIDTH'(1);
          p_r  <= '0;
          cnt  <= '0;
        end
        S_PRE, S_SQR, S_MUL: begin
          x_sh <= {x_sh[WIDTH-2:0], 1'b0};
          p_r  <= prod;
          cnt  <= cnt + 1'b1;
          if (last) begin
            p_r <= '0;
            cnt <= '0;
            if (state == S_PRE) begin
              br   <= prod;
              acc  <= WIDTH'(1);
              idx  <= IW'(WIDTH - 1);
              x_sh <= WIDTH'(1);
              y_r  <= WIDTH'(1);
            end else if (state == S_SQR && exp_r[idx]) begin
              acc  <= prod;
              x_sh <= prod;
              y_r  <= br;
            end else begin
              acc  <= prod;
              idx  <= idx - 1'b1;
              x_sh <= prod;
              y_r  <= prod;
            end
          end
        end
        S_FIN: result <= skip ? '0 : acc;
        default: ;
      endcase
    end
  end

`ifdef RSA_MODEXP_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)              out_err <= 1'b0;
    else if (state == S_FIN) out_err <= range_err;
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed-vector bench for rsa_modexp: results, latency, backpressure, mid-operation reset,
// plus one 16-bit instance.
module tb_rsa_modexp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  base = '0, exp_v = '0, modulus = '0;
  logic        in_ready, out_valid, out_err;
  logic [7:0]  result;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] base16 = '0, exp16 = '0, modulus16 = '0;
  logic        in_ready16, out_valid16, out_err16;
  logic [15:0] result16;

  int errors = 0;
  int checks = 0;

`ifdef RSA_MODEXP_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  rsa_modexp #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .exp(exp_v), .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_err(out_err)
  );

  rsa_modexp #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .base(base16), .exp(exp16), .modulus(modulus16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .out_err(out_err16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Runs one 8-bit operation from IDLE; optionally holds out_ready low for 'hold' cycles.
  task automatic op8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                     input logic [7:0] res, input int lat_exp, input logic err_exp,
                     input int hold, input string tag);
    int lat;
    logic [7:0] held;
    bit stable;
    chk({tag, "/in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; base = b; exp_v = e; modulus = m;
    @(posedge clk); #1;
    in_valid = 1'b0; base = ~b; exp_v = ~e; modulus = ~m;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, lat, lat_exp);
    chk({tag, "/result"}, result, res);
    chk({tag, "/out_err"}, out_err, err_exp);
    chk({tag, "/in_ready_busy"}, in_ready, 0);
    held = result;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; base = 8'd3; exp_v = 8'd3; modulus = 8'd11;
      @(posedge clk); #1;
      if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) chk({tag, "/held_stable"}, stable, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/out_valid_after"}, out_valid, 0);
    chk({tag, "/in_ready_after"}, in_ready, 1);
  endtask

  task automatic op16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                      input logic [15:0] res, input int lat_exp, input string tag);
    int lat;
    chk({tag, "/in_ready_idle"}, in_ready16, 1);
    in_valid16 = 1'b1; base16 = b; exp16 = e; modulus16 = m;
    @(posedge clk); #1;
    in_valid16 = 1'b0; base16 = ~b; exp16 = ~e; modulus16 = ~m;
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, lat, lat_exp);
    chk({tag, "/result"}, result16, res);
    chk({tag, "/out_err"}, out_err16, 0);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    chk({tag, "/in_ready_after"}, in_ready16, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset/in_ready", in_ready, 1);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/result", result, 0);
    chk("reset/out_err", out_err, 0);
    chk("reset/in_ready16", in_ready16, 1);

    // 128^103 mod 143, popcount(103)=5
    op8(8'd128, 8'd103, 8'd143, 8'd2,   114, 1'b0, 0, "rsa_d");
    op8(8'd2,   8'd7,   8'd143, 8'd128, 98,  1'b0, 0, "pow7");
    op8(8'd2,   8'd0,   8'd143, 8'd1,   74,  1'b0, 0, "exp0");
    // 200 >= 143: reduced to 57 normally, error with range check
    op8(8'd200, 8'd1,   8'd143, RC ? 8'd0 : 8'd57, RC ? 2 : 82, RC, 0, "big_base");
    op8(8'd77,  8'd5,   8'd1,   8'd0,   2,   RC,   0, "mod1");
    op8(8'd9,   8'd9,   8'd0,   8'd0,   2,   RC,   0, "mod0");
    op8(8'd5,   8'd3,   8'd7,   8'd6,   90,  1'b0, 0, "small");
    // 142 = -1 mod 143, odd exponent, all bits set
    op8(8'd142, 8'd255, 8'd143, 8'd142, 138, 1'b0, 0, "neg1");
    op8(8'd12,  8'd2,   8'd143, 8'd1,   82,  1'b0, 0, "sq");
    op8(8'd128, 8'd103, 8'd143, 8'd2,   114, 1'b0, 20, "backpressure");
    op8(8'd2,   8'd7,   8'd143, 8'd128, 98,  1'b0, 0, "after_bp");

    // Reset while the first operation is squaring
    in_valid = 1'b1; base = 8'd128; exp_v = 8'd103; modulus = 8'd143;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset/in_ready", in_ready, 1);
    chk("midreset/out_valid", out_valid, 0);
    chk("midreset/result", result, 0);
    op8(8'd128, 8'd103, 8'd143, 8'd2, 114, 1'b0, 0, "post_reset");

    op16(16'd65, 16'd17, 16'd3233, 16'd2790, 306, "w16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
